// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the memory responder.
// State encoding, word geometry and the address range check.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int WORD_BYTES  = 4;
    localparam int DEF_ADDR_W  = 15;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_LATENCY = 4;

    // Any byte-address bit above the word-index field marks an access
    // outside the backing store.
    function automatic logic addr_oob(
        input logic [31:0] addr,
        input int          aw
    );
        return (addr >> (aw + $clog2(WORD_BYTES))) != 32'd0;
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with registered read data.
// Contents are never reset; only the access port is clocked.
module mem_array #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // One access per enable: either commit the word or register it out.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word responder backing the cache.
// One outstanding request; the RAM is touched on the edge entering RESP.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_we,
    output logic              resp_err
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam bit         DIRECT = (LATENCY == 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_err;
    logic              r_rd_ok;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_access;
    logic              w_req_err;
    logic              w_acc_we;
    logic              w_acc_err;
    logic [ADDR_W-1:0] w_acc_idx;
    logic [DATA_W-1:0] w_acc_wdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_accept  = req_valid && req_ready;
    assign w_req_err = addr_oob(req_addr, ADDR_W);

    // With a single-cycle latency the access happens on the accept edge,
    // so the request itself feeds the RAM instead of the captured copy.
    assign w_acc_we    = DIRECT ? req_we    : r_we;
    assign w_acc_err   = DIRECT ? w_req_err : r_err;
    assign w_acc_idx   = DIRECT ? req_addr[ADDR_W+1:2] : r_idx;
    assign w_acc_wdata = DIRECT ? req_wdata : r_wdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: accept, count down the latency, hold until taken.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = DIRECT ? RESP : WAIT;
            WAIT: if (r_cnt == 4'd0) w_next = RESP;
            RESP: if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State-decoded outputs and the RAM access strobe.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        w_access   = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                w_access  = DIRECT && req_valid;
            end
            WAIT: w_access = (r_cnt == 4'd0);
            RESP: resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request capture, latency counter and read-data qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rd_ok <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_err   <= w_req_err;
                r_idx   <= req_addr[ADDR_W+1:2];
                r_wdata <= req_wdata;
                r_cnt   <= LAT_M1;
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_rd_ok <= !w_acc_we && !w_acc_err;
            end
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk     (clk),
        .i_en    (w_access && !w_acc_err),
        .i_we    (w_acc_we),
        .i_addr  (w_acc_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_rdata)
    );

    assign resp_rdata = r_rd_ok ? w_rdata : '0;
    assign resp_we    = r_we;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder.
// Directed scenarios followed by a randomized request stream.
module tb_mem_responder;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 32;
    localparam int LATENCY = 4;

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_we;
    logic        resp_err;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   bp_cnt = 0;
    bit   rr_always = 1'b1;
    bit   prev_v = 1'b0;
    bit   hs_pend = 1'b0;
    exp_t cur;
    exp_t sb[$];
    logic [31:0] model [int];
    int   pool [8];

    mem_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_we    (resp_we),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Drive one request, wait for acceptance, record the expected response.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input bit push);
        exp_t e;
        int   n;
        int   idx;
        bit   err;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            timeout("accept");
            req_valid = 1'b0;
            return;
        end
        err     = (addr >= (32'd4 << ADDR_W));
        idx     = int'(addr / 4);
        e.we    = we;
        e.err   = err;
        e.acc   = cyc + 1;
        e.rdata = '0;
        if (push) begin
            if (!we && !err) e.rdata = model[idx];
            if (we && !err) model[idx] = wd;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_valid || !req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout("idle");
    endtask

    // Monitor: pop on each new response, check timing, fields and stability,
    // then choose resp_ready for the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v     = 1'b0;
            hs_pend    = 1'b0;
            resp_ready = 1'b0;
        end else begin
            if (hs_pend) begin
                check("post_hs_valid", resp_valid, 0);
                check("post_hs_ready", req_ready, 1);
            end
            if (resp_valid) begin
                check("busy_ready", req_ready, 0);
                if (!prev_v) begin
                    if (sb.size() == 0) begin
                        timeout("unexpected_resp");
                    end else begin
                        cur = sb.pop_front();
                        check("latency", cyc, cur.acc + LATENCY);
                        check("resp_we", resp_we, cur.we);
                        check("resp_err", resp_err, cur.err);
                        check("resp_rdata", resp_rdata, cur.rdata);
                    end
                end else begin
                    check("hold_rdata", resp_rdata, cur.rdata);
                    check("hold_we", resp_we, cur.we);
                    check("hold_err", resp_err, cur.err);
                end
            end
            prev_v = resp_valid;
            if (resp_valid && bp_cnt > 0) begin
                resp_ready = 1'b0;
                bp_cnt--;
            end else if (rr_always) begin
                resp_ready = 1'b1;
            end else begin
                resp_ready = ($urandom_range(0, 3) != 0);
            end
            hs_pend = resp_valid && resp_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_we", resp_we, 0);
        check("rst_resp_err", resp_err, 0);

        rr_always = 1'b1;
        issue(1'b1, 32'd0, 32'd42, 1'b1);
        issue(1'b1, 32'd64, 32'd111, 1'b1);
        issue(1'b0, 32'd64, 32'd0, 1'b1);
        issue(1'b0, 32'd66, 32'd0, 1'b1);
        issue(1'b1, 32'h0002_0000, 32'd5000, 1'b1);
        issue(1'b0, 32'd0, 32'd0, 1'b1);
        wait_idle();

        bp_cnt = 6;
        issue(1'b0, 32'd64, 32'd0, 1'b1);
        wait_idle();

        issue(1'b1, 32'd1088, 32'd77, 1'b1);
        issue(1'b1, 32'd1088, 32'd222, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_resp_rdata", resp_rdata, 0);
        check("abort_resp_we", resp_we, 0);
        check("abort_resp_err", resp_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 32'd1088, 32'd0, 1'b1);
        wait_idle();

        issue(1'b1, 32'd64, 32'd111, 1'b1);
        issue(1'b1, 32'd1088, 32'd222, 1'b1);
        issue(1'b1, 32'd3136, 32'd333, 1'b1);
        issue(1'b0, 32'd3136, 32'd0, 1'b1);
        issue(1'b0, 32'd1088, 32'd0, 1'b1);
        issue(1'b0, 32'd64, 32'd0, 1'b1);
        wait_idle();

        rr_always = 1'b0;
        for (int j = 0; j < 8; j++) begin
            pool[j] = int'($urandom_range(0, (1 << ADDR_W) - 1));
        end
        for (int i = 0; i < 60; i++) begin
            int          r;
            int          k;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            k = int'($urandom_range(0, 7));
            a = 32'(pool[k] * 4) + 32'($urandom_range(0, 3));
            if (r == 0) begin
                issue(1'($urandom_range(0, 1)), $urandom | 32'h0002_0000,
                      $urandom, 1'b1);
            end else if (r < 5 || !model.exists(pool[k])) begin
                issue(1'b1, a, $urandom, 1'b1);
            end else begin
                issue(1'b0, a, 32'd0, 1'b1);
            end
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Backing-store responder for the set-associative cache controller's miss/write-through path. Accepts single-word read/write requests from the cache over a valid/ready handshake and returns one response per request after a fixed, parameterised access latency. Models the 32768-word main memory as a synchronous single-port array, so the cache controller's memory model is replaced by a real responder with cycle-accurate timing.

Parameters:
ADDR_W, 15, word-index width; memory depth = 2**ADDR_W words (32768)
DATA_W, 32, data word width
LATENCY, 4, cycles from request acceptance edge to resp_valid rising; legal range 1..15

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  32  byte address; bits [1:0] ignored
req_wdata  in  DATA_W  write data
resp_valid  out  1  response present
resp_ready  in  1  requester accepts response
resp_rdata  out  DATA_W  read data (0 for writes and errors)
resp_we  out  1  echo of captured req_we
resp_err  out  1  address out of range

Behaviour:
- Reset (async assert, sync release): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_we=0, resp_err=0, latency counter=0. Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready at edge T: capture we, addr, wdata; err = |req_addr[31:ADDR_W+2]; load counter=LATENCY-1; go WAIT (or RESP directly if LATENCY==1).
- WAIT: req_ready=0; counter decrements each cycle; at counter==0 on the next edge go RESP. resp_valid rises exactly at edge T+LATENCY.
- Array access occurs on the WAIT->RESP (or IDLE->RESP) edge: write commits word index addr[ADDR_W+1:2] only if !err; read registers array word into resp_rdata if !we && !err, else resp_rdata=0.
- RESP: resp_valid=1, outputs stable until resp_valid&&resp_ready; on that edge clear resp_valid, return to IDLE. req_ready rises the cycle after handshake (no overlap; max one outstanding request).
- Backpressure: resp_ready low holds RESP indefinitely; no new request accepted.
- req_valid changes while req_ready=0 are ignored; requester must hold request until accepted.
- Read-after-write to same address: second request observes written data.
- Reset during WAIT: request aborted, write not committed. Reset during RESP: write already committed, response dropped.
- Unwritten locations read as X in simulation; bench must write before reading.

Decomposition:
- Package mem_pkg: state enum (IDLE, WAIT, RESP), WORD_BYTES=4, default ADDR_W/DATA_W/LATENCY constants, out-of-range check function.
- Sub-module mem_array: single-port synchronous RAM (we, addr, wdata, rdata registered), instantiated once.

Test Plan:
- Write addr=64 data=111 accepted at T -> resp_valid at T+4, resp_we=1, resp_err=0; then read addr=64 -> resp_rdata=111 at accept+4.
- Read addr=66 after above write -> resp_rdata=111 (low bits ignored).
- Write addr=0x0002_0000 data=5000 -> resp_err=1, resp_rdata=0; subsequent read addr=0 returns its prior value, not 5000.
- Read with resp_ready held low 6 cycles -> resp_valid and resp_rdata stable throughout, req_ready=0; handshake returns to IDLE, req_ready=1 one cycle later.
- Write addr=1088 data=222, assert rst_n=0 two cycles after acceptance -> all outputs at reset values immediately; later read addr=1088 does not return 222.
- Back-to-back writes 64/111, 1088/222, 3136/333 then reads in reverse order with resp_ready=1 -> data 333, 222, 111, each resp_valid exactly LATENCY cycles after its acceptance.
